// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - fixed-period PWM DAC fed from a valid/ready sample port or an internal ramp/constant source
// Codes switch only at period boundaries so the filtered output never sees a mid-period glitch.
module pwm_dac #(
    parameter int PRESC = 4,
    parameter int STEP  = 1
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [7:0] const_code,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       pwm_out,
    output logic [7:0] cur_code,
    output logic       period_start,
    output logic       underrun
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

    localparam logic [1:0] MODE_STREAM = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_CONST  = 2'b11;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    code_q, code_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          pend_valid_q, pend_valid_d;
    logic [7:0]    ramp_q, ramp_d;
    logic          dir_q, dir_d;
    logic          started_q, started_d;
    logic          pwm_q, pwm_d;
    logic          period_start_q, period_start_d;
    logic          underrun_q, underrun_d;

    logic          tick;
    logic          boundary;
    logic          accept;
    logic [8:0]    ramp_up;
    logic [8:0]    ramp_dn;

    // started_q holds the counters for the first edge after reset so that edge opens period 0
    assign tick     = started_q && (presc_q == PRESC_MAX);
    assign boundary = tick && (cnt_q == 8'hFF);
    assign s_ready  = started_q && (mode == MODE_STREAM) && !pend_valid_q;
    assign accept   = s_valid && s_ready;
    assign ramp_up  = {1'b0, ramp_q} + 9'(STEP);
    assign ramp_dn  = {1'b0, ramp_q} - 9'(STEP);

    always_comb begin
        presc_d        = presc_q;
        cnt_d          = cnt_q;
        code_d         = code_q;
        pend_data_d    = pend_data_q;
        pend_valid_d   = pend_valid_q;
        ramp_d         = ramp_q;
        dir_d          = dir_q;
        started_d      = 1'b1;
        period_start_d = !started_q || boundary;
        underrun_d     = 1'b0;

        if (started_q) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        if (accept) begin
            pend_data_d  = s_data;
            pend_valid_d = 1'b1;
        end

        // An accept on the boundary edge cannot collide with the clear below: it needs pend_valid_q = 0
        if (boundary) begin
            case (mode)
                MODE_STREAM: begin
                    if (pend_valid_q) begin
                        code_d       = pend_data_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
                MODE_SAW: begin
                    ramp_d = ramp_up[7:0];
                    code_d = ramp_up[7:0];
                end
                MODE_TRI: begin
                    if (!dir_q) begin
                        if (ramp_up[8]) begin
                            ramp_d = 8'hFF;
                            dir_d  = 1'b1;
                        end else begin
                            ramp_d = ramp_up[7:0];
                        end
                    end else begin
                        if (ramp_dn[8]) begin
                            ramp_d = 8'h00;
                            dir_d  = 1'b0;
                        end else begin
                            ramp_d = ramp_dn[7:0];
                        end
                    end
                    code_d = ramp_d;
                end
                MODE_CONST: begin
                    code_d = const_code;
                end
                default: begin
                    code_d = code_q;
                end
            endcase
        end

        pwm_d = (cnt_d < code_d);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            cnt_q          <= 8'h00;
            code_q         <= 8'h00;
            pend_data_q    <= 8'h00;
            pend_valid_q   <= 1'b0;
            ramp_q         <= 8'h00;
            dir_q          <= 1'b0;
            started_q      <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            code_q         <= code_d;
            pend_data_q    <= pend_data_d;
            pend_valid_q   <= pend_valid_d;
            ramp_q         <= ramp_d;
            dir_q          <= dir_d;
            started_q      <= started_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign cur_code     = code_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;

endmodule

// File: doc/pwm_dac.md
# pwm_dac

PWM digital-to-analog generator: the output-direction counterpart of the comparator/PWM ADC path on the same board. It takes 8-bit codes from a valid/ready sample port, or from an internal sawtooth, triangle or constant source. It emits a fixed-period PWM whose duty equals the code, for an external RC filter on an `OUT` header pin. Codes change only at PWM period boundaries, through a one-entry holding register, so the output never glitches mid-period.

## Interface
- `PRESC`, default 4: `CLOCK_50` cycles per PWM count step, ≥1. Period = `PRESC`×256 cycles.
- `STEP`, default 1: ramp increment per period for the sawtooth and triangle modes, 1..255.
- `CLOCK_50` in 1: system clock; sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode` in 2: code source. 00 = sample port, 01 = sawtooth, 10 = triangle, 11 = constant.
- `const_code` in 8: code used in mode 11; typically driven by `SW1`.
- `s_data` in 8: sample code.
- `s_valid` in 1: sample offered.
- `s_ready` out 1: holding register can accept a sample.
- `pwm_out` out 1: registered PWM output.
- `cur_code` out 8: code currently being played, for LEDG/7-seg display.
- `period_start` out 1: one-cycle pulse in the first cycle of each period.
- `underrun` out 1: one-cycle pulse when mode 00 reaches a boundary with no pending sample.

## Operation
- **Prescaler `presc`**: counts 0..`PRESC`−1. A tick occurs when `presc`=`PRESC`−1.
- **`pwm_cnt`** (8 bit): increments on each tick and wraps 255→0.
- **Boundary edge**: the edge where tick and `pwm_cnt`=255.
- **Holding register** (`pend_data`, `pend_valid`):
  - `s_ready` = (`mode`==00) && !`pend_valid`.
  - Accept on `s_valid`&&`s_ready`: `pend_data`←`s_data`, `pend_valid`←1.
  - Contents are retained across mode changes.
- **Next code at a boundary edge**:
  - Mode 00 with `pend_valid`=1: `pend_data`; `pend_valid` is cleared.
  - Mode 00 with `pend_valid`=0: current code is held; `underrun` pulses.
  - Mode 01: `ramp` + `STEP`, mod 256; `ramp` is updated.
  - Mode 10: if `dir`=up, `ramp` + `STEP`. A result >255 clamps to 255 and sets `dir`=down. If `dir`=down, `ramp` − `STEP`. A result <0 clamps to 0 and sets `dir`=up. `ramp` is updated.
  - Mode 11: `const_code`.
- **Ramp state**: `ramp` and `dir` are shared by modes 01 and 10. They advance only in those modes and persist otherwise.
- **Simultaneous accept and boundary**: only possible when `pend_valid`=0. The boundary sees the old (empty) state, so `underrun` pulses and the code is held. The accepted sample lands in pending and plays at the following boundary.
- **Mode or `const_code` changes**: sampled only at a boundary edge; they have no mid-period effect.
- **`pwm_out` register**: loads (next `pwm_cnt` < next code) each cycle.
  - Code 0: never high.
  - Code N: high for N×`PRESC` cycles per period.
  - Code 255: high for 255×`PRESC` cycles per period; 100% duty is not reachable.
- **`cur_code`**: equals the active code register.
- **Reset** (`rst_n` low, immediate): `presc`, `pwm_cnt`, active code, `pend_data`, `pend_valid`, `ramp` all 0; `dir`=up. Outputs `pwm_out`, `cur_code`, `period_start`, `underrun`, `s_ready` all 0.

## Timing
- After `rst_n` rises, the first period starts at the first clock edge.
  - `period_start`=1 in cycle 0 after release; the first boundary pulse follows at cycle `PRESC`×256.
  - `s_ready`=1 from cycle 0 if mode=00.
- **Sample latency**: a sample accepted in period k plays in period k+1, starting exactly at that period's `period_start` cycle.
- **Registered outputs**: `period_start`, `underrun`, `cur_code` and the first `pwm_out` value of the new period all update on the boundary edge.
- **Back-pressure**: `s_ready` drops the cycle after an accept. It rises the cycle after the next boundary edge.
- **Reset mid-period**: `pwm_out` goes low asynchronously and the pending sample is discarded.

## Test plan
1. **Reset and idle**: hold `rst_n` low with `s_valid`=1, `mode`=00. Required: all outputs 0 during reset. After release, `s_ready`=1 and `pwm_out`=0 for the whole first 1024-cycle period. `period_start` pulses at cycles 0 and 1024.
2. **Single sample** (`PRESC`=4): offer 0x40 during period 0. Required: from cycle 1024, `cur_code`=0x40 and `pwm_out` is high for exactly 256 of every 1024 cycles. `underrun` pulses at the cycle-2048 boundary.
3. **Back-pressure**: offer 0x10 then 0x80 back-to-back with `s_valid` held. Required:
   - 0x10 is accepted immediately; 0x80 stalls with `s_ready`=0 until the cycle after the 1024 boundary.
   - Played codes are 0x10 in period 1 and 0x80 in period 2.
   - No `underrun` at the 1024 or 2048 boundaries.
4. **Accept on the boundary edge**: assert `s_valid` for exactly the cycle at 1023 with `pend_valid`=0. Required: `underrun` pulses at 1024 and code 0 is held; the sample plays from cycle 2048.
5. **Triangle** (`STEP`=64, `mode`=10): required `cur_code` sequence per period is 0, 64, 128, 192, 255, 191, 127, 63, 0, 64.
6. **Extremes and reset**:
   - `mode`=11, `const_code`=0xFF: `pwm_out` high for 1020 of 1024 cycles.
   - `const_code`=0x00: `pwm_out` constant 0.
   - Pulse `rst_n` low mid-period: `pwm_out`=0 immediately and `cur_code`=0.
